// File: rtl/inst_mem_axi_pkg.sv
// Shared constants and FSM encoding for the instruction-memory AXI4 read responder.
package inst_mem_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/inst_mem_axi_rd_if.sv
// AXI4 read-channel bundle (AR + R) between the fetch master and the instruction memory.
interface inst_mem_axi_rd_if #(
    parameter int C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_S_AXI_ADDR_WIDTH      = 32,
    parameter int C_S_AXI_DATA_WIDTH      = 32,
    parameter int C_S_AXI_RUSER_WIDTH     = 4
);
    logic [C_S_AXI_THREAD_ID_WIDTH-1:0] arid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]      araddr;
    logic [7:0]                         arlen;
    logic [2:0]                         arsize;
    logic [1:0]                         arburst;
    logic                               arvalid;
    logic                               arready;
    logic [C_S_AXI_THREAD_ID_WIDTH-1:0] rid;
    logic [C_S_AXI_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                         rresp;
    logic                               rlast;
    logic [C_S_AXI_RUSER_WIDTH-1:0]     ruser;
    logic                               rvalid;
    logic                               rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, ruser, rvalid
    );
endinterface

// File: rtl/inst_mem_axi_skid.sv
// Two-entry skid buffer with empty-bypass: a beat arriving while empty is presented the same cycle.
module inst_mem_axi_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);
    logic [W-1:0] e0, e1;
    logic [1:0]   cnt;
    logic         pop_st, push_st;

    assign count     = cnt;
    assign out_valid = (cnt != 2'd0) || in_valid;
    assign out_data  = (cnt != 2'd0) ? e0 : (in_valid ? in_data : '0);
    assign pop_st    = (cnt != 2'd0) && out_ready;
    // Stored only if the beat is not consumed straight through the bypass
    assign push_st   = in_valid && !((cnt == 2'd0) && out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 2'd0;
        else     cnt <= cnt + {1'b0, push_st} - {1'b0, pop_st};
    end

    always_ff @(posedge clk) begin
        if (pop_st) begin
            e0 <= (cnt == 2'd2) ? e1 : in_data;
            if (cnt == 2'd2) e1 <= in_data;
        end else if (push_st) begin
            if (cnt == 2'd0) e0 <= in_data;
            else             e1 <= in_data;
        end
    end
endmodule

// File: rtl/inst_mem_axi_rd.sv
// AXI4 read-only responder serving fetch bursts from a preloadable word RAM.
// Optional feature macro: INST_MEM_AXI_WRAP_EN enables true WRAP bursts (else WRAP behaves as INCR).
module inst_mem_axi_rd
    import inst_mem_axi_pkg::*;
#(
    parameter int          C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter int          C_S_AXI_ADDR_WIDTH      = 32,
    parameter int          C_S_AXI_DATA_WIDTH      = 32,
    parameter int          C_S_AXI_RUSER_WIDTH     = 4,
    parameter logic [31:0] C_MEM_BASE              = 32'h2000_0000,
    parameter int          C_MEM_WORDS             = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    inst_mem_axi_rd_if.slave  axi
);
    localparam int IDW   = C_S_AXI_THREAD_ID_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W = $clog2(C_MEM_WORDS);
    localparam int CW    = ((AW > 32) ? AW : 32) + 1;
    localparam int SKW   = IDW + DW + 3;
    localparam logic [CW-1:0] MEM_LO = CW'(C_MEM_BASE);
    localparam logic [CW-1:0] MEM_HI = MEM_LO + (CW'(C_MEM_WORDS) << 2);

    function automatic logic in_range(input logic [CW-1:0] a);
        return (a >= MEM_LO) && (a < MEM_HI);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [CW-1:0] a);
        return IDX_W'((a - MEM_LO) >> 2);
    endfunction

    logic [DW-1:0]  mem [C_MEM_WORDS];

    state_t         state, state_n;
    logic           arready_r, arready_n, vld_p1, issued_all, issue, ar_hs, r_done;
    logic [IDW-1:0] id_r, id_p1;
    logic [AW-1:0]  addr_r, addr_n;
    logic [7:0]     len_r, beat_r;
    logic [1:0]     burst_r, burst_cap, resp_p1;
    logic           slverr_r, len_bad, last_p1;
    logic [DW-1:0]  ram_q;
    logic [1:0]     skid_cnt;
    logic [SKW-1:0] skid_in, skid_out;
    logic           skid_vld;

    assign ar_hs  = arready_r && axi.arvalid;
    assign r_done = axi.rvalid && axi.rready && axi.rlast;

`ifdef INST_MEM_AXI_WRAP_EN
    logic [AW-1:0] wrap_mask;
    assign wrap_mask = AW'({len_r, 2'b11});
    assign len_bad   = (axi.arburst == BURST_WRAP) &&
                       !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    assign burst_cap = axi.arburst;
`else
    assign len_bad   = 1'b0;
    assign burst_cap = (axi.arburst == BURST_WRAP) ? BURST_INCR : axi.arburst;
`endif

    always_comb begin
        addr_n = addr_r + AW'(4);
        if (burst_r == BURST_FIXED) addr_n = addr_r;
`ifdef INST_MEM_AXI_WRAP_EN
        if (burst_r == BURST_WRAP) addr_n = (addr_r & ~wrap_mask) | (addr_n & wrap_mask);
`endif
    end

    // A new RAM read is issued only if every beat in flight can still land in the skid buffer
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            ST_IDLE:   if (ar_hs) state_n = ST_ISSUE;
            ST_ISSUE: begin
                issue   = 1'b1;
                state_n = ST_STREAM;
            end
            ST_STREAM: begin
                issue = !issued_all && (({1'b0, skid_cnt} + {2'b00, vld_p1}) < 3'd2);
                if (r_done) state_n = ST_IDLE;
            end
            default:   state_n = ST_IDLE;
        endcase
        arready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            arready_r  <= 1'b0;
            vld_p1     <= 1'b0;
            issued_all <= 1'b0;
        end else begin
            state     <= state_n;
            arready_r <= arready_n;
            vld_p1    <= issue;
            if (ar_hs)                        issued_all <= 1'b0;
            else if (issue && beat_r == len_r) issued_all <= 1'b1;
        end
    end

    // Stage p1: RAM read (read-first against the preload port) plus beat attributes
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            id_r     <= axi.arid;
            addr_r   <= axi.araddr & ~AW'(3);
            len_r    <= axi.arlen;
            burst_r  <= burst_cap;
            slverr_r <= (axi.arsize != SIZE_WORD) || len_bad;
            beat_r   <= 8'd0;
        end else if (issue) begin
            beat_r <= beat_r + 8'd1;
            addr_r <= addr_n;
        end
        if (issue) begin
            id_p1   <= id_r;
            last_p1 <= (beat_r == len_r);
            resp_p1 <= slverr_r ? RESP_SLVERR :
                       (in_range(CW'(addr_r)) ? RESP_OKAY : RESP_DECERR);
            ram_q   <= mem[word_idx(CW'(addr_r))];
        end
        if (load_we && in_range(CW'(load_addr))) mem[word_idx(CW'(load_addr))] <= load_data;
    end

    assign skid_in = {id_p1, (resp_p1 == RESP_OKAY) ? ram_q : '0, resp_p1, last_p1};

    inst_mem_axi_skid #(.W(SKW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_data   (skid_in),
        .out_valid (skid_vld),
        .out_data  (skid_out),
        .out_ready (axi.rready),
        .count     (skid_cnt)
    );

    assign {axi.rid, axi.rdata, axi.rresp, axi.rlast} = skid_out;
    assign axi.rvalid  = skid_vld;
    assign axi.arready = arready_r;
    assign axi.ruser   = '0;
endmodule

// File: tb/tb_inst_mem_axi_rd.sv
// Bench for inst_mem_axi_rd: table-driven bursts, randomized bursts against an arithmetic memory model.
module tb_inst_mem_axi_rd;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          WORDS = 4096;
`ifdef INST_MEM_AXI_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [31:0] load_addr, load_data;

    always #5 clk = ~clk;

    inst_mem_axi_rd_if #(.C_S_AXI_THREAD_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32),
                         .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_RUSER_WIDTH(4)) axi ();

    inst_mem_axi_rd #(.C_MEM_BASE(BASE), .C_MEM_WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .axi       (axi)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [WORDS];

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          mode;
        logic [1:0]  exp_first;
        logic [1:0]  exp_last;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected beat k of a burst, computed directly from the address/response rules.
    function automatic void exp_beat(input logic [31:0] a0, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input int k, output logic [31:0] d, output logic [1:0] r);
        longint a, w, lo, ad;
        bit bad;
        a   = longint'(a0 & 32'hFFFF_FFFC);
        w   = 4 * (longint'(len) + 1);
        bad = (size != 3'b010);
        if (burst == 2'b00) ad = a;
        else if (WRAP_EN && burst == 2'b10) begin
            lo = a - (a % w);
            ad = lo + ((a - lo + 4 * longint'(k)) % w);
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
        end else ad = (a + 4 * longint'(k)) % 64'h1_0000_0000;
        if (bad) begin
            d = 32'h0; r = 2'b10;
        end else if (ad < longint'(BASE) || ad >= longint'(BASE) + 4 * WORDS) begin
            d = 32'h0; r = 2'b11;
        end else begin
            d = mem_m[int'((ad - longint'(BASE)) / 4)];
            r = 2'b00;
        end
    endfunction

    task automatic model_load(input logic [31:0] a, input logic [31:0] d);
        if (a >= BASE && a < BASE + 32'h4000) mem_m[int'((a - BASE) >> 2)] = d;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_we = 1'b0;
        model_load(a, d);
    endtask

    // mode 0: RREADY held high; 1: RREADY pattern 1,0,0,1; 2: random RREADY
    task automatic run_burst(input logic id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode,
                             output logic [1:0] r_first, output logic [1:0] r_last);
        int          waitc, cyc, beat;
        logic        held;
        logic [35:0] hv;
        logic [31:0] ed;
        logic [1:0]  er;
        r_first = 2'bxx;
        r_last  = 2'bxx;
        @(negedge clk);
        axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1; axi.rready = 1'b0;
        waitc = 0;
        while (!axi.arready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("arready_wait", 64'(axi.arready), 64'(1));
        if (!axi.arready) begin
            axi.arvalid = 1'b0;
            return;
        end
        beat = 0; cyc = 0; held = 1'b0; hv = '0;
        while (beat <= int'(len) && cyc < 16 * (int'(len) + 1) + 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                axi.arvalid = 1'b0;
                chk("rvalid_before_latency", 64'(axi.rvalid), 64'(0));
            end
            if (cyc == 2) chk("first_rvalid_latency", 64'(axi.rvalid), 64'(1));
            if (held) begin
                chk("stall_rvalid_held", 64'(axi.rvalid), 64'(1));
                chk("stall_payload_stable", 64'({axi.rid, axi.rdata, axi.rresp, axi.rlast}), 64'(hv));
                held = 1'b0;
            end
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
            if (axi.rvalid && axi.rready) begin
                exp_beat(a, len, size, burst, beat, ed, er);
                chk($sformatf("rdata_beat%0d", beat), 64'(axi.rdata), 64'(ed));
                chk($sformatf("rresp_beat%0d", beat), 64'(axi.rresp), 64'(er));
                chk($sformatf("rlast_beat%0d", beat), 64'(axi.rlast), 64'(beat == int'(len)));
                chk($sformatf("rid_beat%0d", beat), 64'(axi.rid), 64'(id));
                if (beat == 0) r_first = axi.rresp;
                if (beat == int'(len)) r_last = axi.rresp;
                beat++;
            end else if (axi.rvalid) begin
                held = 1'b1;
                hv   = {axi.rid, axi.rdata, axi.rresp, axi.rlast};
            end
        end
        chk("beat_count", 64'(beat), 64'(int'(len) + 1));
        @(negedge clk);
        axi.rready = 1'b0;
        chk("arready_after_last", 64'(axi.arready), 64'(1));
        chk("no_extra_beat", 64'(axi.rvalid), 64'(0));
    endtask

    logic [1:0]  rf, rl;
    logic [31:0] old_d, ra;
    int          waitc, cyc, nb;

    initial begin
        rst = 1'b1;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'b010;
        axi.arburst = 2'b01; axi.arvalid = 1'b0; axi.rready = 1'b0;

        @(negedge clk);
        chk("reset_arready", 64'(axi.arready), 64'(0));
        chk("reset_rvalid", 64'(axi.rvalid), 64'(0));
        chk("reset_rdata", 64'(axi.rdata), 64'(0));
        chk("reset_rlast_rresp_rid", 64'({axi.rlast, axi.rresp, axi.rid}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            load_we = 1'b1; load_addr = BASE + 32'(i * 4); load_data = $urandom;
            model_load(load_addr, load_data);
        end
        @(negedge clk);
        load_we = 1'b0;
        for (int i = 0; i < 8; i++) load_word(BASE + 32'(i * 4), 32'h1000_0000 + 32'(i));

        vecs[0]  = '{1'b0, 32'h2000_0000, 8'd7,  3'b010, 2'b01, 0, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 32'h2000_0000, 8'd7,  3'b010, 2'b01, 1, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 32'h2000_3FF8, 8'd3,  3'b010, 2'b01, 0, 2'b00, 2'b11};
        vecs[3]  = '{1'b0, 32'h2000_0000, 8'd1,  3'b001, 2'b01, 0, 2'b10, 2'b10};
        vecs[4]  = '{1'b1, 32'h2000_0008, 8'd3,  3'b010, 2'b10, 1, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 32'h2000_0010, 8'd4,  3'b010, 2'b00, 2, 2'b00, 2'b00};
        vecs[6]  = '{1'b0, 32'h1FFF_FFF0, 8'd3,  3'b010, 2'b01, 0, 2'b11, 2'b11};
        vecs[7]  = '{1'b1, 32'h2000_3FFC, 8'd0,  3'b010, 2'b01, 0, 2'b00, 2'b00};
        vecs[8]  = '{1'b0, 32'h2000_4000, 8'd1,  3'b010, 2'b00, 1, 2'b11, 2'b11};
        vecs[9]  = '{1'b1, 32'h2000_0023, 8'd2,  3'b010, 2'b01, 2, 2'b00, 2'b00};
        vecs[10] = '{1'b0, 32'h2000_0000, 8'd2,  3'b010, 2'b10, 0,
                     WRAP_EN ? 2'b10 : 2'b00, WRAP_EN ? 2'b10 : 2'b00};
        vecs[11] = '{1'b0, 32'h1FFF_FFF8, 8'd3,  3'b010, 2'b01, 2, 2'b11, 2'b00};
        vecs[12] = '{1'b1, 32'h2000_0100, 8'd0,  3'b011, 2'b00, 0, 2'b10, 2'b10};
        vecs[13] = '{1'b0, 32'h2000_3FF0, 8'd15, 3'b010, 2'b01, 1, 2'b00, 2'b11};

        for (int v = 0; v < 14; v++) begin
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      vecs[v].mode, rf, rl);
            chk($sformatf("vec%0d_first_resp", v), 64'(rf), 64'(vecs[v].exp_first));
            chk($sformatf("vec%0d_last_resp", v), 64'(rl), 64'(vecs[v].exp_last));
        end

        // Out-of-range preload writes must not alias onto in-range words
        load_word(BASE + 32'h4000, 32'hDEAD_0001);
        load_word(BASE - 32'd4, 32'hDEAD_0002);
        run_burst(1'b0, BASE, 8'd0, 3'b010, 2'b01, 0, rf, rl);
        run_burst(1'b0, BASE + 32'h3FFC, 8'd0, 3'b010, 2'b01, 0, rf, rl);

        // Preload write to the word being read in the same cycle returns old data
        ra    = BASE + 32'd400;
        old_d = mem_m[100];
        @(negedge clk);
        axi.arid = 1'b0; axi.araddr = ra; axi.arlen = 8'd0; axi.arsize = 3'b010;
        axi.arburst = 2'b01; axi.arvalid = 1'b1; axi.rready = 1'b1;
        waitc = 0;
        while (!axi.arready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("rf_arready", 64'(axi.arready), 64'(1));
        @(negedge clk);
        axi.arvalid = 1'b0;
        load_we = 1'b1; load_addr = ra; load_data = 32'hCAFE_F00D;
        @(negedge clk);
        load_we = 1'b0;
        chk("rf_rvalid", 64'(axi.rvalid), 64'(1));
        chk("rf_old_data", 64'(axi.rdata), 64'(old_d));
        model_load(ra, 32'hCAFE_F00D);
        @(negedge clk);
        axi.rready = 1'b0;
        run_burst(1'b1, ra, 8'd0, 3'b010, 2'b01, 0, rf, rl);

        for (int n = 0; n < 24; n++) begin
            run_burst(1'($urandom_range(0, 1)),
                      BASE - 32'd64 + 32'($urandom_range(0, 16384 + 128)),
                      8'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010,
                      2'($urandom_range(0, 2)),
                      2, rf, rl);
        end

        // Asynchronous reset while beat 2 of an 8-beat burst is on the bus
        @(negedge clk);
        axi.arid = 1'b0; axi.araddr = BASE; axi.arlen = 8'd7; axi.arsize = 3'b010;
        axi.arburst = 2'b01; axi.arvalid = 1'b1; axi.rready = 1'b1;
        waitc = 0;
        while (!axi.arready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("rst_test_arready", 64'(axi.arready), 64'(1));
        nb = 0; cyc = 0;
        while (nb < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            axi.arvalid = 1'b0;
            if (axi.rvalid) nb++;
        end
        @(negedge clk);
        chk("beat2_rvalid", 64'(axi.rvalid), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", 64'(axi.rvalid), 64'(0));
        chk("async_rst_arready", 64'(axi.arready), 64'(0));
        chk("async_rst_rdata", 64'(axi.rdata), 64'(0));
        axi.rready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arready_after_rst", 64'(axi.arready), 64'(1));
        chk("rvalid_after_rst", 64'(axi.rvalid), 64'(0));
        run_burst(1'b1, BASE + 32'h20, 8'd3, 3'b010, 2'b01, 0, rf, rl);
        chk("post_rst_resp", 64'({rf, rl}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
